sr_cmd_sequencer: RTL and testbench

Upstream command stage for the SR flip-flop (S, R, CLK → Q).
- Accepts set/reset requests over a valid/ready handshake.
- Drives exactly one of S/R for a programmed hold time, waits for the flip-flop's two-register latency, then checks the fed-back Q.
- Reports DONE on match; retries up to MAX_RETRY times, then reports ERR.
- Never drives S and R high together, so the FF's hold-on-both path is never exercised.

---
 rtl/sr_seq_pkg.sv | 30 +++
 rtl/sr_seq_timer.sv | 40 ++++
 rtl/sr_cmd_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_seq_pkg
// Purpose  : Shared types and constants for the SR command sequencer.
//            State encoding for the sequencer FSM, op encoding, and a
//            helper that sizes the retry counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sr_seq_pkg;

  // Sequencer FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  // Request op encoding: which FF input gets driven.
  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Width needed to count 0..max_retry; never less than one bit.
  function automatic int unsigned retry_width(input int unsigned max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : sr_seq_timer
// Purpose  : Loadable down-counter used to time the DRIVE and SETTLE phases.
//            load has priority over en; the count holds at zero.
// Ports    : CLK      - clock, rising edge
//            RST_N    - asynchronous active-low reset (clears count)
//            load     - load load_val this cycle
//            en       - decrement when not zero
//            load_val - value to load
//            zero     - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module sr_seq_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_sequencer
// Purpose  : Upstream command stage for an SR flip-flop. Accepts set/reset
//            requests over valid/ready, drives exactly one of S/R for
//            HOLD_CYC cycles, waits SETTLE_CYC cycles for the FF's
//            two-register latency, checks Q_FB and reports DONE, retrying up
//            to MAX_RETRY times before reporting ERR.
//            Optional macro SR_SEQ_SKIP_EN: when defined, a request whose op
//            already matches Q_FB completes immediately (DONE next cycle,
//            no S/R activity).
// Ports    : CLK       - clock, rising edge
//            RST_N     - asynchronous active-low reset
//            REQ_VALID - request present
//            REQ_OP    - 1 = set, 0 = reset; sampled on handshake
//            REQ_READY - sequencer can accept a request (registered)
//            S, R      - registered drives to the FF, never both high
//            Q_FB      - FF Q output fed back (synchronous to CLK)
//            BUSY      - high in any state except IDLE
//            DONE      - one-cycle pulse, Q_FB matched the request
//            ERR       - one-cycle pulse, retries exhausted
// Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_sequencer
  import sr_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ_VALID,
  input  logic REQ_OP,
  output logic REQ_READY,
  output logic S,
  output logic R,
  input  logic Q_FB,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  localparam int unsigned      c_rty_w       = retry_width(MAX_RETRY);
  localparam logic [CNT_W-1:0] c_hold_load   = CNT_W'(HOLD_CYC - 1);
  // SETTLE_CYC = 0 bypasses SETTLE entirely; the load value is then unused.
  localparam logic [CNT_W-1:0] c_settle_load =
    CNT_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
  localparam logic [c_rty_w-1:0] c_max_retry = c_rty_w'(MAX_RETRY);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic               r_op;
  logic [c_rty_w-1:0] r_retry;
  logic               r_ready;
  logic               r_s;
  logic               r_r;
  logic               r_done;
  logic               r_err;

  // --------------------------------------------------------------------------
  // Next-state signals
  // --------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic               w_op_nxt;
  logic [c_rty_w-1:0] w_retry_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic               w_tmr_load;
  logic               w_tmr_en;
  logic [CNT_W-1:0]   w_tmr_val;
  logic               w_tmr_zero;
  logic               w_skip;

`ifdef SR_SEQ_SKIP_EN
  // FF already holds the requested value: nothing to drive.
  assign w_skip = (Q_FB == REQ_OP);
`else
  assign w_skip = 1'b0;
`endif

  sr_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (w_tmr_load),
    .en       (w_tmr_en),
    .load_val (w_tmr_val),
    .zero     (w_tmr_zero)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_retry_nxt = r_retry;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    w_tmr_val   = c_hold_load;

    case (r_state)
      ST_IDLE: begin
        if (REQ_VALID && r_ready) begin
          w_op_nxt    = REQ_OP;
          w_retry_nxt = '0;
          if (w_skip) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DRIVE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_hold_load;
          end
        end
      end

      ST_DRIVE: begin
        if (w_tmr_zero) begin
          if (SETTLE_CYC == 0) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_settle_load;
          end
        end else begin
          w_tmr_en = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_tmr_en = 1'b1;
        end
      end

      ST_CHECK: begin
        if (Q_FB == r_op) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_retry < c_max_retry) begin
          w_retry_nxt = r_retry + 1'b1;
          w_state_nxt = ST_DRIVE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_hold_load;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers. S/R/READY are derived from the next state so they line up
  // with the state they belong to, with no combinational path to outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_op    <= OP_RESET;
      r_retry <= '0;
      r_ready <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_retry <= w_retry_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_s     <= (w_state_nxt == ST_DRIVE) && (w_op_nxt == OP_SET);
      r_r     <= (w_state_nxt == ST_DRIVE) && (w_op_nxt == OP_RESET);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign REQ_READY = r_ready;
  assign S         = r_s;
  assign R         = r_r;
  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = r_done;
  assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_cmd_sequencer
// Purpose  : Directed testbench for sr_cmd_sequencer with default parameters
//            and a two-register SR flip-flop model on the feedback path.
//            Per-cycle outputs are collected into bit masks indexed by the
//            cycle number after the handshake, then compared against
//            hand-computed masks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_sequencer;

  logic CLK       = 1'b0;
  logic RST_N     = 1'b0;
  logic REQ_VALID = 1'b0;
  logic REQ_OP    = 1'b0;
  logic REQ_READY;
  logic S;
  logic R;
  logic Q_FB;
  logic BUSY;
  logic DONE;
  logic ERR;

  // SR flip-flop model: S/R -> intermediate -> Q, two registers.
  logic ff_mid = 1'b0;
  logic ff_q   = 1'b0;
  logic stuck  = 1'b0;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_both;
  logic [4:0]  cyc_n;
  logic [31:0] m_s, m_r, m_done, m_err, m_busy, m_rdy, m_q;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (S)      ff_mid <= 1'b1;
    else if (R) ff_mid <= 1'b0;
    ff_q <= ff_mid;
  end

  assign Q_FB = stuck ? 1'b0 : ff_q;

  sr_cmd_sequencer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_OP    (REQ_OP),
    .REQ_READY (REQ_READY),
    .S         (S),
    .R         (R),
    .Q_FB      (Q_FB),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc_n  = '0;
    n_both = 0;
    m_s = '0; m_r = '0; m_done = '0; m_err = '0;
    m_busy = '0; m_rdy = '0; m_q = '0;
  endtask

  // Advance one cycle and record outputs 1 time unit after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
    cyc_n = cyc_n + 5'd1;
    m_s[cyc_n]    = S;
    m_r[cyc_n]    = R;
    m_done[cyc_n] = DONE;
    m_err[cyc_n]  = ERR;
    m_busy[cyc_n] = BUSY;
    m_rdy[cyc_n]  = REQ_READY;
    m_q[cyc_n]    = Q_FB;
    if (S && R) n_both++;
  endtask

  // Present a request for one edge; returns in cycle 1 after the handshake.
  task automatic hs(input logic op);
    REQ_VALID = 1'b1;
    REQ_OP    = op;
    cyc();
    REQ_VALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    clr();
    cyc();
    cyc();
    chk("reset_outputs {S,R,BUSY,RDY,DONE,ERR}",
        32'({S, R, BUSY, REQ_READY, DONE, ERR}), 32'h0);
    RST_N = 1'b1;
    cyc();
    chk("ready_after_reset", 32'({REQ_READY, BUSY}), 32'h2);

    // ---------------- 1: set with defaults ----------------
    clr();
    hs(1'b1);
    repeat (6) cyc();
    chk("t1_S",    m_s,    32'h0000_0002);
    chk("t1_R",    m_r,    32'h0);
    chk("t1_DONE", m_done, 32'h0000_0020);
    chk("t1_ERR",  m_err,  32'h0);
    chk("t1_BUSY", m_busy, 32'h0000_001E);
    chk("t1_RDY",  m_rdy,  32'h0000_00E0);
    chk("t1_QFB",  m_q,    32'h0000_00F8);

    // ---------------- 2: reset after set ----------------
    clr();
    hs(1'b0);
    repeat (6) cyc();
    chk("t2_S",    m_s,    32'h0);
    chk("t2_R",    m_r,    32'h0000_0002);
    chk("t2_DONE", m_done, 32'h0000_0020);
    chk("t2_BUSY", m_busy, 32'h0000_001E);
    chk("t2_QFB",  m_q,    32'h0000_0006);

    // ---------------- 3: Q_FB stuck at 0, retries exhausted ----------------
    stuck = 1'b1;
    clr();
    hs(1'b1);
    repeat (14) cyc();
    chk("t3_S",    m_s,    32'h0000_0222);
    chk("t3_R",    m_r,    32'h0);
    chk("t3_DONE", m_done, 32'h0);
    chk("t3_ERR",  m_err,  32'h0000_2000);
    chk("t3_BUSY", m_busy, 32'h0000_1FFE);
    chk("t3_RDY",  m_rdy,  32'h0000_E000);
    stuck = 1'b0;
    cyc();

    // ---------------- 6: set while Q_FB already 1 ----------------
    chk("t6_QFB_pre", 32'(Q_FB), 32'h1);
    clr();
    hs(1'b1);
    repeat (6) cyc();
    chk("t6_R", m_r, 32'h0);
`ifdef SR_SEQ_SKIP_EN
    chk("t6_S",    m_s,    32'h0);
    chk("t6_DONE", m_done, 32'h0000_0002);
    chk("t6_BUSY", m_busy, 32'h0);
    chk("t6_RDY",  m_rdy,  32'h0000_00FE);
`else
    chk("t6_S",    m_s,    32'h0000_0002);
    chk("t6_DONE", m_done, 32'h0000_0020);
    chk("t6_BUSY", m_busy, 32'h0000_001E);
    chk("t6_RDY",  m_rdy,  32'h0000_00E0);
`endif

    // Return the FF to 0 ahead of the back-to-back test.
    clr();
    hs(1'b0);
    repeat (6) cyc();
    chk("clear_DONE", m_done, 32'h0000_0020);

    // ---------------- 4: back-to-back set then reset ----------------
    clr();
    hs(1'b1);
    repeat (4) cyc();
    hs(1'b0);
    repeat (6) cyc();
    chk("t4_S",    m_s,    32'h0000_0002);
    chk("t4_R",    m_r,    32'h0000_0040);
    chk("t4_DONE", m_done, 32'h0000_0420);
    chk("t4_BUSY", m_busy, 32'h0000_03DE);
    chk("t4_RDY",  m_rdy,  32'h0000_1C20);
    chk("t4_SR_both", 32'(n_both), 32'h0);

    // ---------------- 5: reset asserted during SETTLE ----------------
    clr();
    hs(1'b1);
    cyc();
    chk("t5_settle {S,R,BUSY}", 32'({S, R, BUSY}), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("t5_async {S,R,BUSY,RDY,DONE,ERR}",
        32'({S, R, BUSY, REQ_READY, DONE, ERR}), 32'h0);
    cyc();
    cyc();
    RST_N = 1'b1;
    repeat (5) cyc();
    chk("t5_DONE", m_done, 32'h0);
    chk("t5_ERR",  m_err,  32'h0);
    chk("t5_BUSY", m_busy, 32'h0000_0006);
    chk("t5_RDY",  m_rdy,  32'h0000_03E0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
